// File: rtl/aline_readout.sv
`default_nettype none
// =============================================================================
// aline_readout : reads one stored A-line from sample RAM after each
// acquisition and streams it as a packetised, back-pressurable 14-bit stream.
// Option macro: ALINE_SIGN_CONVERT_EN (offset binary -> two's complement out)
// Revision: 1.0
// =============================================================================
module aline_readout #(
  parameter int NSAMPLES    = 1170,
  parameter int RAM_LATENCY = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic        clk_system,
  input  logic        global_reset_n,
  input  logic        acq_busy,
  output logic [10:0] ram_rd_addr,
  output logic        ram_rd_en,
  input  logic [13:0] ram_rd_data,
  output logic [13:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_sop,
  output logic        out_eop,
  output logic        rd_busy,
  output logic        overrun,
  input  logic        clear_overrun,
  output logic [15:0] line_count
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + RAM_LATENCY + 1);
  localparam logic [10:0]      LAST_IDX = 11'(NSAMPLES - 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state, state_next;

  logic                   sync1, sync2, sync2_q, acq_done;
  logic [10:0]            rd_addr_q;
  logic [10:0]            ret_idx;
  logic [RAM_LATENCY-1:0] rd_pipe;
  logic [CNT_W-1:0]       inflight;
  logic [CNT_W-1:0]       fifo_count, fifo_count_next;
  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic                   issue, push, pop, room;
  logic [13:0]            mem_word [FIFO_DEPTH];
  logic [10:0]            mem_idx  [FIFO_DEPTH];
  logic [13:0]            head_word, conv_word;
  logic [10:0]            head_idx;

  // Two-flop synchronizer followed by a registered falling-edge detect.
  always_ff @(posedge clk_system or negedge global_reset_n) begin
    if (!global_reset_n) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      sync2_q  <= 1'b0;
      acq_done <= 1'b0;
    end else begin
      sync1    <= acq_busy;
      sync2    <= sync1;
      sync2_q  <= sync2;
      acq_done <= sync2_q & ~sync2;
    end
  end

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RAM_LATENCY; i++) begin
      inflight = inflight + CNT_W'(rd_pipe[i]);
    end
  end

  assign push            = rd_pipe[RAM_LATENCY-1];
  assign out_valid       = (fifo_count != '0);
  assign pop             = out_valid & out_ready;
  assign room            = (fifo_count + inflight) < DEPTH_C;
  assign fifo_count_next = fifo_count + CNT_W'(push) - CNT_W'(pop);

  always_comb begin
    state_next = state;
    issue      = 1'b0;
    case (state)
      IDLE: begin
        if (acq_done) state_next = READ;
      end
      READ: begin
        if (room) begin
          issue = 1'b1;
          if (rd_addr_q == LAST_IDX) state_next = DRAIN;
        end
      end
      DRAIN: begin
        // Leave as the final word is handed off so rd_busy drops right after eop.
        if ((inflight == '0) && (fifo_count_next == '0)) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_system or negedge global_reset_n) begin
    if (!global_reset_n) begin
      state     <= IDLE;
      rd_addr_q <= '0;
      ret_idx   <= '0;
      rd_pipe   <= '0;
    end else begin
      state   <= state_next;
      rd_pipe <= (rd_pipe << 1) | RAM_LATENCY'(issue);
      if (state == IDLE) begin
        rd_addr_q <= '0;
      end else if (issue) begin
        rd_addr_q <= (rd_addr_q == LAST_IDX) ? 11'd0 : rd_addr_q + 11'd1;
      end
      if (state == IDLE) begin
        ret_idx <= '0;
      end else if (push) begin
        ret_idx <= (ret_idx == LAST_IDX) ? 11'd0 : ret_idx + 11'd1;
      end
    end
  end

  assign ram_rd_en   = issue;
  assign ram_rd_addr = rd_addr_q;

  always_ff @(posedge clk_system or negedge global_reset_n) begin
    if (!global_reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      fifo_count <= fifo_count_next;
      if (push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: every output derived from it is gated by out_valid.
  always_ff @(posedge clk_system) begin
    if (push) begin
      mem_word[wr_ptr] <= ram_rd_data;
      mem_idx[wr_ptr]  <= ret_idx;
    end
  end

  assign head_word = mem_word[rd_ptr];
  assign head_idx  = mem_idx[rd_ptr];

`ifdef ALINE_SIGN_CONVERT_EN
  assign conv_word = {~head_word[13], head_word[12:0]};
`else
  assign conv_word = head_word;
`endif

  assign out_data = out_valid ? conv_word : 14'd0;
  assign out_sop  = out_valid & (head_idx == 11'd0);
  assign out_eop  = out_valid & (head_idx == LAST_IDX);
  assign rd_busy  = (state != IDLE);

  always_ff @(posedge clk_system or negedge global_reset_n) begin
    if (!global_reset_n) begin
      overrun    <= 1'b0;
      line_count <= '0;
    end else begin
      if (acq_done && (state != IDLE)) begin
        overrun <= 1'b1;
      end else if (clear_overrun) begin
        overrun <= 1'b0;
      end
      if (pop && out_eop) line_count <= line_count + 16'd1;
    end
  end

endmodule
`default_nettype wire

// File: doc/aline_readout.md
# aline_readout

Reads one stored A-line out of the sample RAM after each acquisition completes and streams it to the host path as a packetised, back-pressurable 14-bit stream. It sits on clk_system downstream of the acquisition block. Whenever acq_busy falls, it issues NSAMPLES RAM reads, buffers the returning words, and emits them with start- and end-of-packet markers.

## Interface
- NSAMPLES, 1170: samples per A-line; RAM addresses read are 0..NSAMPLES-1.
- RAM_LATENCY, 2: clk_system cycles from ram_rd_en/ram_rd_addr to valid ram_rd_data.
- FIFO_DEPTH, 4: output buffer entries; must be >= RAM_LATENCY+2.

Ports:
- clk_system  in  1  system clock; all logic on rising edge.
- global_reset_n  in  1  asynchronous, active-low reset.
- acq_busy  in  1  high while an A-line is being written; asynchronous to clk_system.
- ram_rd_addr  out  11  RAM read address.
- ram_rd_en  out  1  read strobe.
- ram_rd_data  in  14  RAM read data, RAM_LATENCY cycles after the strobe.
- out_data  out  14  stream data.
- out_valid  out  1  out_data holds a word.
- out_ready  in  1  sink accepts the word; a transfer occurs when out_valid && out_ready.
- out_sop  out  1  first word of the line, qualified by out_valid.
- out_eop  out  1  last word of the line, qualified by out_valid.
- rd_busy  out  1  state != IDLE.
- overrun  out  1  sticky; set when an A-line completes while readout is busy.
- clear_overrun  in  1  synchronous clear of overrun.
- line_count  out  16  number of completed line transfers (eop handshakes).

## Operation
- acq_busy passes through a 2-flop synchronizer and then a registered falling-edge detect, producing acq_done as a 1-cycle pulse.
- State IDLE:
  - on acq_done, go to READ and set the address counter to 0.
- State READ:
  - issue a read (ram_rd_en=1, ram_rd_addr=counter) in any cycle where fifo_count + inflight < FIFO_DEPTH.
  - after issuing address NSAMPLES-1, go to DRAIN.
- State DRAIN:
  - when inflight==0 and the FIFO is empty, go to IDLE.
- inflight tracks outstanding reads in a RAM_LATENCY-deep valid shift register; each returning word is written into the FIFO.
- The FIFO is show-ahead: out_data is the head entry and out_valid = !empty.
- A word index travels with each entry:
  - out_sop=1 iff index==0.
  - out_eop=1 iff index==NSAMPLES-1.
- line_count increments on the eop handshake and wraps from 65535 to 0.
- acq_done while state != IDLE, including the final DRAIN cycle, sets overrun and the line is not read.
  - If clear_overrun and a new overrun occur in the same cycle, set wins.
- A rising edge of acq_busy during READ or DRAIN has no effect.
- Reset mid-line flushes the FIFO, discards in-flight reads, and never emits a partial eop.

## Timing
- Reset values:
  - ram_rd_addr=0, ram_rd_en=0.
  - out_data=0, out_valid=0, out_sop=0, out_eop=0.
  - rd_busy=0, overrun=0, line_count=0.
  - State=IDLE, synchronizer flops = 0.
- acq_busy first sampled low at edge N: acq_done is high in cycle N+3, and the state is READ in cycle N+4 with the first read issued.
- Read issued in cycle R: the data is written into the FIFO at the end of cycle R+RAM_LATENCY, and out_valid rises in cycle R+RAM_LATENCY+1.
- With out_ready held high: 1 word per cycle with no gaps, so a full line takes NSAMPLES cycles of out_valid.
- With out_ready low: out_data, out_sop and out_eop hold stable, and reads stall once fifo_count + inflight == FIFO_DEPTH. No word is dropped or duplicated.
- rd_busy falls in the cycle after the eop handshake empties the pipeline.

## Configuration
- ALINE_SIGN_CONVERT_EN:
  - Defined: out_data = {~word[13], word[12:0]}, converting offset binary to two's complement at the FIFO output.
  - Undefined: out_data = word unchanged.
  - No timing difference either way.

## Test plan
- NSAMPLES=8; RAM holds addr*3; acq_busy pulses high then falls; out_ready=1 -> out_data sequence 0,3,...,21; out_sop on word 0 and out_eop on word 7; line_count=1; 8 consecutive valid cycles.
- Same setup with out_ready toggling 1,0,0,1,... -> identical data sequence, output held stable while stalled, ram_rd_en never raised when fifo_count + inflight = 4.
- Second acq_busy fall during READ -> overrun=1, only 8 words emitted, line_count=1; clear_overrun pulse -> overrun=0.
- global_reset_n asserted after word 3 -> all outputs return to reset values immediately; a following acquisition emits a complete line starting with sop.
- 65536 lines streamed (NSAMPLES=2) -> line_count wraps to 0; with ALINE_SIGN_CONVERT_EN, RAM word 0x2000 is emitted as 0x0000.
